id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  Sits directly downstream of the 32x64 register file.
//  - Takes ReadData1/ReadData2 for the instruction in ID.
//  - Resolves RAW hazards by bypassing results from EX, MEM and WB.
//  - Detects load-use hazards and stalls IF/ID.
//  - Registers the resolved operands and control into the ID/EX pipeline register that feeds the ALU.
// PARAMETERS
//  DATA_W  64  operand/result width
//  CTRL_W  8   opaque EX/MEM control bundle width, passed through unchanged
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  reset_n        in   1       synchronous, active-low reset
//  id_valid       in   1       ID holds a real instruction
//  id_rn          in   5       source reg A (drives regfile ReadRegister1)
//  id_rm          in   5       source reg B (drives regfile ReadRegister2)
//  id_rd          in   5       destination reg
//  id_uses_rn     in   1       instruction reads rn
//  id_uses_rm     in   1       instruction reads rm
//  id_regwrite    in   1       instruction writes rd
//  id_memread     in   1       instruction is a load
//  id_ctrl        in   CTRL_W  remaining control
//  id_imm         in   DATA_W  sign-extended immediate
//  rf_data1       in   DATA_W  regfile ReadData1
//  rf_data2       in   DATA_W  regfile ReadData2
//  ex_alu_result  in   DATA_W  combinational ALU result for the current ID/EX contents
//  mem_regwrite   in   1       MEM-stage instr writes mem_rd
//  mem_rd         in   5
//  mem_result     in   DATA_W  MEM writeback value (load data for loads)
//  wb_regwrite    in   1       WB writes wb_rd this cycle (regfile RegWrite)
//  wb_rd          in   5
//  wb_data        in   DATA_W  regfile WriteData
//  flush          in   1       taken branch: kill the instruction in ID
//  stall_out      out  1       hold PC and IF/ID this cycle
//  ex_valid, ex_regwrite, ex_memread  out 1     registered ID/EX control
//  ex_rd          out  5
//  ex_ctrl        out  CTRL_W
//  ex_imm, ex_opa, ex_opb  out  DATA_W  registered immediate and resolved operands
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): every registered output is 0. stall_out is combinational from those, so it is 0.
//  - Hit on source s:
//      EX   = ex_valid  & ex_regwrite  & ex_rd==s  & s!=XZR
//      MEM  = mem_regwrite & mem_rd==s & s!=XZR
//      WB   = wb_regwrite  & wb_rd==s  & s!=XZR
//  - Operand select priority: EX > MEM > WB > rf_data.
//  - XZR (31) is never bypassed; it always yields rf_data (=0).
//  - WB bypass is required: the regfile write lands on the same edge, so rf_data is stale for one cycle.
//  - Load-use: load_use = id_valid & ex_valid & ex_memread & ex_rd!=XZR
//      & ((id_uses_rn & ex_rd==id_rn) | (id_uses_rm & ex_rd==id_rm)).
//  - stall_out = load_use & ~flush (combinational, same cycle).
//  - Next-edge update, highest priority first:
//      1. ~reset_n: all zero.
//      2. flush | load_use | ~id_valid: bubble. ex_valid=ex_regwrite=ex_memread=0, other fields 0.
//      3. otherwise: load id_* and the resolved operands.
//  - Latency: 1 cycle from ID to ex_* outputs.
//  - A stall lasts exactly 1 cycle. The bubble clears ex_memread, so a held instruction re-evaluates and then hits MEM bypass.
//  - flush with load_use at the same time: flush wins, no stall.
//  - Reset mid-stall: bubble cleared, stall_out drops the cycle after reset.
//  - ex_opb carries register rm. The immediate-vs-register choice is made in EX from ex_ctrl.
// STRUCTURE
//  - cpu_pkg holds: localparam XZR = 5'd31; DATA_W; typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM, FWD_EX} fwd_sel_t.
//  - Sub-module operand_bypass_mux, instantiated twice (A and B).
//      in:  src reg, rf_data, 3 candidate results
//      out: operand and fwd_sel_t (fwd_sel_t exported for coverage)
//  - Top level holds the hazard logic and the ID/EX flops.
// TESTING
//  1. reset_n=0 for 2 cycles, id_valid=1
//     -> all ex_* = 0, stall_out=0.
//  2. ADD X1 in EX (ex_alu_result=0x10), ID reads rn=X1
//     -> ex_opa=0x10 next cycle, fwd sel=FWD_EX.
//  3. MEM X2=0xAA, WB X2=0xBB, rf=0xCC, ID reads rm=X2
//     -> ex_opb=0xAA.
//  4. Same as 3 with MEM inactive
//     -> ex_opb=0xBB.
//  5. WB writes X31=0x55, ID reads X31, rf=0
//     -> ex_opa=0.
//  6. LDUR X3 in EX, ID ADD reads X3
//     -> stall_out=1 for 1 cycle, bubble (ex_valid=0).
//     Next cycle MEM X3=0x77 -> ex_opa=0x77, ex_valid=1.
//  7. Repeat 6 with flush=1 in the stall cycle
//     -> stall_out=0, ex_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the ID/EX operand path.
// Holds the zero-register index, default datapath width and the bypass source encoding.
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// Picks one source operand from EX, MEM, WB or the regfile, youngest producer first.
// Combinational, zero latency; no flow control.
module operand_bypass_mux #(
    parameter int W = 64
) (
    input  logic [4:0]         src,
    input  logic [W-1:0]       rf_data,
    input  logic               ex_wr,
    input  logic [4:0]         ex_rd,
    input  logic [W-1:0]       ex_data,
    input  logic               mem_wr,
    input  logic [4:0]         mem_rd,
    input  logic [W-1:0]       mem_data,
    input  logic               wb_wr,
    input  logic [4:0]         wb_rd,
    input  logic [W-1:0]       wb_data,
    output logic [W-1:0]       operand,
    output cpu_pkg::fwd_sel_t  sel
);
    import cpu_pkg::*;

    always_comb begin
        operand = rf_data;
        sel     = FWD_RF;
        // XZR reads as zero from the regfile no matter who claims to write it
        if (src != XZR) begin
            if (ex_wr && ex_rd == src) begin
                operand = ex_data;
                sel     = FWD_EX;
            end else if (mem_wr && mem_rd == src) begin
                operand = mem_data;
                sel     = FWD_MEM;
            end else if (wb_wr && wb_rd == src) begin
                operand = wb_data;
                sel     = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Resolves ID operands with EX/MEM/WB bypass, detects load-use, and registers the ID/EX stage.
// Latency 1 cycle ID->ex_*; load-use raises stall_out for one cycle and inserts a bubble.
module id_ex_operand_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [4:0]         id_rn,
    input  logic [4:0]         id_rm,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rn,
    input  logic               id_uses_rm,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [DATA_W-1:0]  rf_data1,
    input  logic [DATA_W-1:0]  rf_data2,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic               mem_regwrite,
    input  logic [4:0]         mem_rd,
    input  logic [DATA_W-1:0]  mem_result,
    input  logic               wb_regwrite,
    input  logic [4:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               stall_out,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic [4:0]         ex_rd,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_opa,
    output logic [DATA_W-1:0]  ex_opb,
    output cpu_pkg::fwd_sel_t  fwd_sel_a,
    output cpu_pkg::fwd_sel_t  fwd_sel_b
);
    import cpu_pkg::*;

    logic              ex_wr;
    logic              load_use;
    logic              bubble;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    assign ex_wr = ex_valid & ex_regwrite;

    operand_bypass_mux #(.W(DATA_W)) u_bypass_a (
        .src      (id_rn),
        .rf_data  (rf_data1),
        .ex_wr    (ex_wr),
        .ex_rd    (ex_rd),
        .ex_data  (ex_alu_result),
        .mem_wr   (mem_regwrite),
        .mem_rd   (mem_rd),
        .mem_data (mem_result),
        .wb_wr    (wb_regwrite),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .operand  (opa),
        .sel      (fwd_sel_a)
    );

    operand_bypass_mux #(.W(DATA_W)) u_bypass_b (
        .src      (id_rm),
        .rf_data  (rf_data2),
        .ex_wr    (ex_wr),
        .ex_rd    (ex_rd),
        .ex_data  (ex_alu_result),
        .mem_wr   (mem_regwrite),
        .mem_rd   (mem_rd),
        .mem_data (mem_result),
        .wb_wr    (wb_regwrite),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .operand  (opb),
        .sel      (fwd_sel_b)
    );

    // Load data only exists from MEM onward, so a consumer right behind a load must wait one cycle
    assign load_use = id_valid & ex_valid & ex_memread & (ex_rd != XZR)
                    & ((id_uses_rn & (ex_rd == id_rn)) | (id_uses_rm & (ex_rd == id_rm)));
    assign stall_out = load_use & ~flush;
    assign bubble    = flush | load_use | ~id_valid;

    always_ff @(posedge clk) begin
        if (!reset_n || bubble) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_imm      <= '0;
            ex_opa      <= '0;
            ex_opb      <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
            ex_imm      <= id_imm;
            ex_opa      <= opa;
            ex_opb      <= opb;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: per-cycle model comparison plus literal checks.
module tb_id_ex_operand_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_memread;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic [7:0]  id_ctrl;
    logic [63:0] id_imm, rf_data1, rf_data2, ex_alu_result, mem_result, wb_data;
    logic        mem_regwrite, wb_regwrite, flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        stall_out, ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    logic [7:0]  ex_ctrl;
    logic [63:0] ex_imm, ex_opa, ex_opb;
    fwd_sel_t    fwd_sel_a, fwd_sel_b;

    int total = 0;
    int bad = 0;

    id_ex_operand_stage #(.DATA_W(64), .CTRL_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_ctrl(id_ctrl), .id_imm(id_imm),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .ex_alu_result(ex_alu_result),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm),
        .ex_opa(ex_opa), .ex_opb(ex_opb),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of the ID/EX register contents
    logic        m_valid = 0, m_regwrite = 0, m_memread = 0, live = 0;
    logic [4:0]  m_rd = 0;
    logic [7:0]  m_ctrl = 0;
    logic [63:0] m_imm = 0, m_opa = 0, m_opb = 0;

    // Producers listed youngest first; the first one naming the register supplies it
    function automatic void resolve(input logic [4:0] s, input logic [63:0] rf,
                                    output logic [63:0] v, output fwd_sel_t k);
        logic        wr [3];
        logic [4:0]  rd [3];
        logic [63:0] d  [3];
        fwd_sel_t    ks [3];
        wr = '{m_valid && m_regwrite, mem_regwrite, wb_regwrite};
        rd = '{m_rd, mem_rd, wb_rd};
        d  = '{ex_alu_result, mem_result, wb_data};
        ks = '{FWD_EX, FWD_MEM, FWD_WB};
        v = rf;
        k = FWD_RF;
        if (s != 5'd31) begin
            for (int i = 0; i < 3; i++) begin
                if (k == FWD_RF && wr[i] && rd[i] == s) begin
                    v = d[i];
                    k = ks[i];
                end
            end
        end
    endfunction

    function automatic logic model_lu();
        logic a_dep, b_dep;
        a_dep = id_uses_rn && (id_rn == m_rd);
        b_dep = id_uses_rm && (id_rm == m_rd);
        return id_valid && m_valid && m_memread && (m_rd != 5'd31) && (a_dep || b_dep);
    endfunction

    always @(posedge clk) begin
        logic [63:0] va, vb;
        fwd_sel_t    ka, kb;
        logic        kill;
        resolve(id_rn, rf_data1, va, ka);
        resolve(id_rm, rf_data2, vb, kb);
        kill = !reset_n || flush || model_lu() || !id_valid;
        if (!reset_n) live = 1;
        m_valid    = kill ? 1'b0 : 1'b1;
        m_regwrite = kill ? 1'b0 : id_regwrite;
        m_memread  = kill ? 1'b0 : id_memread;
        m_rd       = kill ? 5'd0 : id_rd;
        m_ctrl     = kill ? 8'd0 : id_ctrl;
        m_imm      = kill ? 64'd0 : id_imm;
        m_opa      = kill ? 64'd0 : va;
        m_opb      = kill ? 64'd0 : vb;
    end

    always @(negedge clk) begin
        logic [63:0] va, vb;
        fwd_sel_t    ka, kb;
        if (live) begin
            resolve(id_rn, rf_data1, va, ka);
            resolve(id_rm, rf_data2, vb, kb);
            chk("m_valid", ex_valid, m_valid);
            chk("m_regwrite", ex_regwrite, m_regwrite);
            chk("m_memread", ex_memread, m_memread);
            chk("m_rd", ex_rd, m_rd);
            chk("m_ctrl", ex_ctrl, m_ctrl);
            chk("m_imm", ex_imm, m_imm);
            chk("m_opa", ex_opa, m_opa);
            chk("m_opb", ex_opb, m_opb);
            chk("m_stall", stall_out, model_lu() && !flush);
            chk("m_sel_a", fwd_sel_a, ka);
            chk("m_sel_b", fwd_sel_b, kb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_rn = 0; id_rm = 0; id_rd = 0;
        id_uses_rn = 0; id_uses_rm = 0; id_regwrite = 0; id_memread = 0;
        id_ctrl = 0; id_imm = 0; rf_data1 = 0; rf_data2 = 0; ex_alu_result = 0;
        mem_regwrite = 0; mem_rd = 0; mem_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    task automatic instr(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic urn, input logic urm, input logic rw, input logic mr);
        id_valid = 1; id_rn = rn; id_rm = rm; id_rd = rd;
        id_uses_rn = urn; id_uses_rm = urm; id_regwrite = rw; id_memread = mr;
        id_ctrl = {rd, 3'b101};
        id_imm = 64'h100 + {59'd0, rd};
    endtask

    initial begin
        clr();
        reset_n = 0;
        instr(5'd1, 5'd2, 5'd3, 1, 1, 1, 1);
        rf_data1 = 64'h1234; rf_data2 = 64'h5678;
        tick();
        tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_regwrite", ex_regwrite, 0);
        chk("rst_memread", ex_memread, 0);
        chk("rst_opa", ex_opa, 0);
        chk("rst_opb", ex_opb, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_stall", stall_out, 0);
        reset_n = 1;

        // EX bypass
        clr();
        instr(5'd2, 5'd3, 5'd1, 1, 1, 1, 0);
        rf_data1 = 64'h20; rf_data2 = 64'h30;
        tick();
        instr(5'd1, 5'd5, 5'd4, 1, 0, 1, 0);
        ex_alu_result = 64'h10; rf_data1 = 64'h99;
        #1;
        chk("ex_sel_a", fwd_sel_a, FWD_EX);
        tick();
        chk("ex_fwd_opa", ex_opa, 64'h10);
        chk("ex_fwd_valid", ex_valid, 1);

        // MEM beats WB beats regfile
        instr(5'd5, 5'd2, 5'd6, 0, 1, 1, 0);
        mem_regwrite = 1; mem_rd = 5'd2; mem_result = 64'hAA;
        wb_regwrite = 1; wb_rd = 5'd2; wb_data = 64'hBB; rf_data2 = 64'hCC;
        tick();
        chk("mem_fwd_opb", ex_opb, 64'hAA);
        instr(5'd5, 5'd2, 5'd7, 0, 1, 1, 0);
        mem_regwrite = 0;
        tick();
        chk("wb_fwd_opb", ex_opb, 64'hBB);

        // XZR never bypassed
        instr(5'd31, 5'd0, 5'd8, 1, 0, 1, 0);
        wb_rd = 5'd31; wb_data = 64'h55;
        mem_regwrite = 1; mem_rd = 5'd31; mem_result = 64'h66; rf_data1 = 0;
        tick();
        chk("xzr_opa", ex_opa, 0);

        // Load-use stall then MEM bypass
        clr();
        instr(5'd8, 5'd9, 5'd3, 1, 0, 1, 1);
        rf_data1 = 64'h1;
        tick();
        instr(5'd3, 5'd10, 5'd9, 1, 1, 1, 0);
        rf_data1 = 64'hDEAD;
        #1;
        chk("lu_stall", stall_out, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_once", stall_out, 0);
        mem_regwrite = 1; mem_rd = 5'd3; mem_result = 64'h77;
        tick();
        chk("lu_mem_opa", ex_opa, 64'h77);
        chk("lu_retry_valid", ex_valid, 1);

        // Flush overrides load-use
        clr();
        instr(5'd8, 5'd9, 5'd3, 1, 0, 1, 1);
        tick();
        instr(5'd3, 5'd10, 5'd9, 1, 1, 1, 0);
        flush = 1;
        #1;
        chk("flush_stall", stall_out, 0);
        tick();
        chk("flush_valid", ex_valid, 0);

        // Load to XZR never stalls
        clr();
        instr(5'd8, 5'd9, 5'd31, 1, 0, 1, 1);
        tick();
        instr(5'd31, 5'd10, 5'd9, 1, 1, 1, 0);
        #1;
        chk("xzr_lu_stall", stall_out, 0);
        tick();
        chk("xzr_lu_valid", ex_valid, 1);

        // rm-side dependency counts only when rm is actually read
        clr();
        instr(5'd8, 5'd9, 5'd12, 1, 0, 1, 1);
        tick();
        instr(5'd1, 5'd12, 5'd9, 1, 1, 1, 0);
        #1;
        chk("rm_lu_stall", stall_out, 1);
        id_uses_rm = 0;
        #1;
        chk("rm_unused_stall", stall_out, 0);
        tick();

        // Reset in the middle of a stall
        clr();
        instr(5'd8, 5'd9, 5'd3, 1, 0, 1, 1);
        tick();
        instr(5'd3, 5'd10, 5'd9, 1, 1, 1, 0);
        #1;
        chk("rst_lu_stall", stall_out, 1);
        reset_n = 0;
        tick();
        chk("rst_mid_stall", stall_out, 0);
        chk("rst_mid_valid", ex_valid, 0);
        reset_n = 1;
        clr();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
